bchecc_seq: RTL and testbench

//  BCH ECC sequencer between the ECC SFR block and the BCH encode/decode core.

---
 rtl/bchecc_seq_if.sv | 24 ++
 rtl/bchecc_seq.sv | 141 ++++++++++++++
 tb/tb_bchecc_seq.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bchecc_seq_if.sv
// Data-path and BCH core handshake bundle for the ECC sequencer.
// master: the sequencer side; slave: the data path / BCH core side.
interface bchecc_seq_if;
   logic       dat_vld_i;
   logic       dat_rdy_o;
   logic       core_start_o;
   logic       core_mode_o;
   logic       core_din_vld_o;
   logic       core_last_o;
   logic       core_done_i;
   logic       core_err_i;
   logic       core_fail_i;
   logic [3:0] core_errcnt_i;

   modport master (
      input  dat_vld_i, core_done_i, core_err_i, core_fail_i, core_errcnt_i,
      output dat_rdy_o, core_start_o, core_mode_o, core_din_vld_o, core_last_o
   );

   modport slave (
      output dat_vld_i, core_done_i, core_err_i, core_fail_i, core_errcnt_i,
      input  dat_rdy_o, core_start_o, core_mode_o, core_din_vld_o, core_last_o
   );
endinterface

// File: rtl/bchecc_seq.sv
// BCH ECC sequencer: starts the core, streams one block of bytes into it,
// waits for the result (with timeout) and reports status back to the SFR block.
module bchecc_seq #(
   parameter int unsigned T_MAX     = 8,
   parameter int unsigned TO_CYCLES = 4095
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [3:0]         ecc_ctrl_i,
   input  logic [9:0]         ecc_cfg_i,
   bchecc_seq_if.master       bus,
   output logic               ecc_busy_o,
   output logic               ecc_block_o,
   output logic               ecc_error_o,
   output logic               correct_fail_o,
   output logic [3:0]         error_cnt_o,
   output logic               change_stat_o
);

   localparam logic [3:0]  TMax  = 4'(T_MAX);
   localparam logic [11:0] ToMax = 12'(TO_CYCLES);

   typedef enum logic [2:0] {StIdle, StStart, StData, StWait, StReport} state_e;

   state_e      state_q;
   logic        start_q;
   logic        busy_q;
   logic        mode_q;
   logic [9:0]  len_q;
   logic [9:0]  cnt_q;
   logic [11:0] timer_q;
   logic        err_q;
   logic        fail_q;
   logic [3:0]  errcnt_q;

   logic go;
   logic abort;
   logic din_vld;
   logic over;

   assign go      = ecc_ctrl_i[0] & ~start_q & ecc_ctrl_i[2] & ~ecc_ctrl_i[3];
   assign abort   = ecc_ctrl_i[3] | ~ecc_ctrl_i[2];
   assign din_vld = bus.dat_vld_i & bus.dat_rdy_o;
   assign over    = bus.core_errcnt_i > TMax;

   assign bus.dat_rdy_o      = (state_q == StData);
   // An abort seen during START suppresses the core start pulse.
   assign bus.core_start_o   = (state_q == StStart) & ~abort;
   assign bus.core_mode_o    = mode_q;
   assign bus.core_din_vld_o = din_vld;
   assign bus.core_last_o    = din_vld & (cnt_q == len_q);

   assign ecc_busy_o     = busy_q;
   assign ecc_block_o    = (state_q == StData);
   assign ecc_error_o    = err_q;
   assign correct_fail_o = fail_q;
   assign error_cnt_o    = errcnt_q;
   assign change_stat_o  = (state_q == StReport);

   // Sequencer FSM with start-edge detect, byte counter, timeout timer and result latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
         mode_q   <= 1'b0;
         len_q    <= '0;
         cnt_q    <= '0;
         timer_q  <= '0;
         err_q    <= 1'b0;
         fail_q   <= 1'b0;
         errcnt_q <= '0;
      end else begin
         start_q <= ecc_ctrl_i[0];
         unique case (state_q)
            StIdle: begin
               if (go) begin
                  state_q <= StStart;
                  busy_q  <= 1'b1;
                  len_q   <= ecc_cfg_i;
                  mode_q  <= ecc_ctrl_i[1];
               end
            end
            StStart: begin
               if (abort) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q   <= '0;
                  state_q <= StData;
               end
            end
            StData: begin
               if (abort) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else if (din_vld) begin
                  cnt_q <= cnt_q + 10'd1;
                  if (cnt_q == len_q) begin
                     state_q <= StWait;
                     timer_q <= '0;
                  end
               end
            end
            StWait: begin
               if (abort) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else if (bus.core_done_i) begin
                  state_q <= StReport;
                  if (mode_q) begin
                     err_q    <= bus.core_err_i | bus.core_fail_i;
                     fail_q   <= bus.core_fail_i | over;
                     errcnt_q <= over ? TMax : bus.core_errcnt_i;
                  end else begin
                     err_q    <= 1'b0;
                     fail_q   <= 1'b0;
                     errcnt_q <= '0;
                  end
               end else if (timer_q == ToMax) begin
                  state_q  <= StReport;
                  err_q    <= 1'b1;
                  fail_q   <= 1'b1;
                  errcnt_q <= '0;
               end else begin
                  timer_q <= timer_q + 12'd1;
               end
            end
            StReport: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bchecc_seq.sv
// Self-checking bench for bchecc_seq: directed scenarios plus randomized blocks
// compared against a rule-level model of the reported status.
module tb_bchecc_seq;
   localparam int unsigned TMax     = 8;
   localparam int unsigned ToCycles = 4095;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] ecc_ctrl;
   logic [9:0] ecc_cfg;
   logic       ecc_busy, ecc_block, ecc_error, correct_fail, change_stat;
   logic [3:0] error_cnt;

   bchecc_seq_if bus ();

   bchecc_seq #(.T_MAX(TMax), .TO_CYCLES(ToCycles)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ecc_ctrl_i     (ecc_ctrl),
      .ecc_cfg_i      (ecc_cfg),
      .bus            (bus),
      .ecc_busy_o     (ecc_busy),
      .ecc_block_o    (ecc_block),
      .ecc_error_o    (ecc_error),
      .correct_fail_o (correct_fail),
      .error_cnt_o    (error_cnt),
      .change_stat_o  (change_stat)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Expected status as the status register should currently show it.
   logic       exp_err  = 1'b0;
   logic       exp_fail = 1'b0;
   logic [3:0] exp_cnt  = 4'd0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_results(input string tag);
      check({tag, "_err"},  ecc_error,    exp_err);
      check({tag, "_fail"}, correct_fail, exp_fail);
      check({tag, "_cnt"},  error_cnt,    exp_cnt);
   endtask

   // Status rules for a block that ended with core_done.
   task automatic model(input logic mode, input int n, input logic e, input logic f);
      if (!mode) begin
         exp_err = 0; exp_fail = 0; exp_cnt = 0;
      end else begin
         exp_err  = e | f;
         exp_fail = f | (n > TMax);
         exp_cnt  = (n > TMax) ? 4'(TMax) : 4'(n);
      end
   endtask

   // abort_after: -1 none, -2 abort in START, k>=0 abort after k bytes.
   task automatic run_block(input logic mode, input int len, input int errcnt, input logic err,
                            input logic fail, input int abort_after, input bit timeout,
                            input bit stall, input bit hold);
      int bytes;
      int guard;
      int d;
      int k;
      logic v;
      @(negedge clk); ecc_ctrl = 4'b0100; bus.dat_vld_i = 0; bus.core_done_i = 0; #1;
      @(negedge clk); ecc_ctrl = {2'b01, mode, 1'b1}; ecc_cfg = len[9:0]; #1;
      check("idle_busy", ecc_busy, 0);
      check("idle_start", bus.core_start_o, 0);
      @(negedge clk);
      ecc_ctrl[0] = hold ? 1'b1 : 1'($urandom_range(0, 1));
      ecc_cfg = 10'($urandom);
      if (abort_after == -2) ecc_ctrl[3] = 1'b1;
      #1;
      check("start_pulse", bus.core_start_o, (abort_after == -2) ? 0 : 1);
      check("start_busy", ecc_busy, 1);
      check("start_rdy", bus.dat_rdy_o, 0);
      check("start_mode", bus.core_mode_o, mode);
      check_results("start_held");
      if (abort_after == -2) begin
         @(negedge clk); ecc_ctrl = 4'b0100; #1;
         check("sabort_busy", ecc_busy, 0);
         check("sabort_stat", change_stat, 0);
         return;
      end
      bytes = 0;
      guard = 0;
      while (bytes <= len) begin
         @(negedge clk);
         ecc_ctrl[0] = hold ? 1'b1 : 1'($urandom_range(0, 1));
         ecc_cfg = 10'($urandom);
         bus.core_done_i = 1'($urandom_range(0, 1));
         if (abort_after >= 0 && bytes == abort_after) begin
            bus.dat_vld_i = 0;
            if ($urandom_range(0, 1) != 0) ecc_ctrl[3] = 1'b1;
            else ecc_ctrl[2] = 1'b0;
            @(negedge clk); bus.dat_vld_i = 1; #1;
            check("abort_busy", ecc_busy, 0);
            check("abort_rdy", bus.dat_rdy_o, 0);
            check("abort_dvld", bus.core_din_vld_o, 0);
            check("abort_stat", change_stat, 0);
            check_results("abort_hold");
            ecc_ctrl = 4'b0100; bus.dat_vld_i = 0; bus.core_done_i = 0;
            return;
         end
         v = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
         bus.dat_vld_i = v;
         #1;
         check("data_rdy", bus.dat_rdy_o, 1);
         check("data_block", ecc_block, 1);
         check("data_dvld", bus.core_din_vld_o, v);
         check("data_last", bus.core_last_o, v && (bytes == len));
         if (v) bytes++;
         guard++;
         if (guard > 8000) begin
            check("data_bound", 0, 1);
            return;
         end
      end
      bus.core_done_i = 0;
      if (timeout) begin
         k = 0;
         forever begin
            @(negedge clk); bus.dat_vld_i = 1'($urandom_range(0, 1)); #1;
            if (change_stat) break;
            if (k == 0) begin
               check("to_rdy", bus.dat_rdy_o, 0);
               check("to_dvld", bus.core_din_vld_o, 0);
            end
            k++;
            if (k > 6000) break;
         end
         check("to_latency", k, ToCycles + 1);
         exp_err = 1; exp_fail = 1; exp_cnt = 0;
         check_results("to_res");
      end else begin
         d = $urandom_range(0, 10);
         for (int i = 0; i <= d; i++) begin
            @(negedge clk);
            bus.dat_vld_i     = 1'($urandom_range(0, 1));
            bus.core_err_i    = 1'($urandom_range(0, 1));
            bus.core_fail_i   = 1'($urandom_range(0, 1));
            bus.core_errcnt_i = 4'($urandom);
            if (i == d) begin
               bus.core_done_i   = 1;
               bus.core_err_i    = err;
               bus.core_fail_i   = fail;
               bus.core_errcnt_i = 4'(errcnt);
            end
            #1;
            check("wait_rdy", bus.dat_rdy_o, 0);
            check("wait_dvld", bus.core_din_vld_o, 0);
            check("wait_stat", change_stat, 0);
            check("wait_busy", ecc_busy, 1);
         end
         @(negedge clk); bus.core_done_i = 0; #1;
         check("rep_stat", change_stat, 1);
         model(mode, errcnt, err, fail);
         check_results("rep_res");
      end
      @(negedge clk); #1;
      check("post_stat", change_stat, 0);
      check("post_busy", ecc_busy, 0);
      check_results("post_hold");
      if (hold) begin
         for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("hold_busy", ecc_busy, 0);
         end
      end
   endtask

   initial begin
      rst_n = 0; ecc_ctrl = 0; ecc_cfg = 0;
      bus.dat_vld_i = 0; bus.core_done_i = 0; bus.core_err_i = 0;
      bus.core_fail_i = 0; bus.core_errcnt_i = 0;
      #1;
      check("rst_busy", ecc_busy, 0);
      check("rst_block", ecc_block, 0);
      check("rst_stat", change_stat, 0);
      check("rst_rdy", bus.dat_rdy_o, 0);
      check("rst_start", bus.core_start_o, 0);
      check("rst_mode", bus.core_mode_o, 0);
      check_results("rst");
      repeat (3) @(negedge clk);
      rst_n = 1;

      run_block(1, 3, 2, 1, 0, -1, 0, 0, 0);
      run_block(0, 0, 5, 1, 0, -1, 0, 0, 0);
      run_block(1, 7, 12, 0, 0, -1, 0, 0, 0);
      run_block(1, 2, 0, 0, 0, -1, 1, 0, 0);
      run_block(1, 7, 3, 1, 0, 2, 0, 0, 0);
      run_block(1, 7, 3, 1, 0, -1, 0, 1, 0);
      run_block(1, 4, 1, 0, 1, -2, 0, 0, 0);
      run_block(0, 5, 0, 0, 0, -1, 0, 1, 1);

      // Start edge with enable low must not launch a run.
      @(negedge clk); ecc_ctrl = 4'b0000; #1;
      @(negedge clk); ecc_ctrl = 4'b0001; #1;
      @(negedge clk); #1;
      check("noen_busy", ecc_busy, 0);
      check("noen_start", bus.core_start_o, 0);

      // Asynchronous reset in the middle of DATA.
      @(negedge clk); ecc_ctrl = 4'b0100;
      @(negedge clk); ecc_ctrl = 4'b0111; ecc_cfg = 10'd10;
      @(negedge clk);
      @(negedge clk); bus.dat_vld_i = 1; #1;
      check("mid_rdy", bus.dat_rdy_o, 1);
      #2 rst_n = 0; #1;
      check("mrst_busy", ecc_busy, 0);
      check("mrst_block", ecc_block, 0);
      check("mrst_rdy", bus.dat_rdy_o, 0);
      check("mrst_dvld", bus.core_din_vld_o, 0);
      check("mrst_mode", bus.core_mode_o, 0);
      check("mrst_stat", change_stat, 0);
      exp_err = 0; exp_fail = 0; exp_cnt = 0;
      check_results("mrst");
      @(negedge clk); rst_n = 1; bus.dat_vld_i = 0; ecc_ctrl = 4'b0100;

      // Largest block length.
      run_block(0, 1023, 0, 0, 0, -1, 0, 0, 0);

      for (int r = 0; r < 25; r++) begin
         int len;
         int ab;
         len = $urandom_range(0, 40);
         ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : -1;
         run_block(1'($urandom_range(0, 1)), len, $urandom_range(0, 15),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ab, 0,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
